watch_set_ctrl: RTL and testbench
=================================

# watch_set_ctrl

- Time-set controller for `Digital_Clock`, running on the same 1 Hz clock.
- Converts three synchronized push-button levels (mode, up, down) into the datapath's `clock_enable` and single-cycle `hour_inc`/`hour_dec`/`min_inc`/`min_dec` pulses.
- Adds a RUN → SET_HOUR → SET_MIN state machine, hold-to-repeat, and an inactivity timeout back to RUN.
- Sits between the button synchronizers and `Digital_Clock`; its outputs wire directly to the same-named datapath inputs.

## Interface

Parameters:
- `TIMEOUT`, default 30: idle cycles in a SET state before automatic return to RUN (≥1).
- `REPEAT_DELAY`, default 2: cycles a held up/down must persist before the first repeat pulse (≥1).
- `REPEAT_RATE`, default 1: cycles between repeat pulses after the first repeat (≥1).

Ports:
- `Clk_1sec` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `btn_mode` in 1: mode button level, already synchronized and debounced.
- `btn_up` in 1: up button level.
- `btn_down` in 1: down button level.
- `clock_enable` out 1: 1 = datapath seconds run.
- `hour_inc` out 1: one-cycle pulse.
- `hour_dec` out 1: one-cycle pulse.
- `min_inc` out 1: one-cycle pulse.
- `min_dec` out 1: one-cycle pulse.
- `mode` out 2: current state, for display blink logic.

## Operation

- States (`mode` encoding): RUN=0, SET_HOUR=1, SET_MIN=2; encoding 3 is unused and recovers to RUN on the next edge.
- Transitions on a mode press (rising edge of `btn_mode`): RUN→SET_HOUR→SET_MIN→RUN.
- In a SET state, when the idle counter reaches `TIMEOUT`, the state goes to RUN.
- `clock_enable`:
  - 1 in RUN, 0 in SET_HOUR/SET_MIN, so seconds freeze while setting.
  - Seconds are not cleared on exit.
- Up/down events: a press is a rising edge, `btn_x`=1 while its previous sample is 0.
  - A press emits one pulse.
  - While held, a repeat pulse is emitted at hold-count = `REPEAT_DELAY`, then every `REPEAT_RATE` cycles.
- Event routing:
  - SET_HOUR: up→`hour_inc`, down→`hour_dec`.
  - SET_MIN: up→`min_inc`, down→`min_dec`.
  - RUN: events are discarded. No pulses, repeat counters still track.
- Simultaneous events:
  - Up and down both high: no pulse, and both hold counters are cleared.
  - Mode press in the same cycle as an up/down event: mode wins, no inc/dec pulse, and both hold counters are cleared.
- Idle counter:
  - Cleared on entry to any SET state and on any cycle where any button is high.
  - Increments otherwise and saturates at `TIMEOUT`.
- At most one of the four inc/dec outputs is high in any cycle.
- Button held across reset: the previous-sample registers reset to 1, so the button must be released before it can register a press. No spurious event occurs after reset.

## Timing

- Every output is registered.
- Reset values: `mode`=RUN, `clock_enable`=0, all inc/dec=0, hold and idle counters=0.
- `clock_enable` goes to 1 on the first edge after `reset` deasserts.
- Latency: an input sampled at edge k produces its output change after edge k, visible during cycle k→k+1.
- Pulses are exactly one cycle wide. Repeat pulses are separated by ≥1 low cycle only when `REPEAT_RATE`≥2; at `REPEAT_RATE`=1 they are back-to-back.
- Hold counter width: $clog2(REPEAT_DELAY+REPEAT_RATE+1).
  - After the first repeat it wraps back to `REPEAT_DELAY` and never overflows.
  - It clears when the button is released.
- Idle counter width: $clog2(TIMEOUT+1).
- Reset asserted mid-operation, including mid-hold in SET_MIN: at the next edge all outputs return to their reset values and no pulse is emitted.
- Timeout and mode press on the same edge: the state goes to RUN exactly once.

## Structure

- Package `watch_pkg`: the `mode` encoding constants (`MODE_RUN`, `MODE_SET_HOUR`, `MODE_SET_MIN`) and a 2-bit mode typedef, shared with the display/blink logic.
- Sub-module `btn_repeat`, instantiated twice (up, down):
  - Inputs: clock, reset, level, `clr`.
  - Output: one-cycle `event`.
  - Contains the previous-sample register (reset 1), edge detection and the hold counter.
  - Takes `REPEAT_DELAY`/`REPEAT_RATE` as parameters.
- The top level holds the FSM, idle counter, conflict resolution and output registers.

## Test plan

All scenarios use default parameters.

- Reset, then 3 idle cycles → `mode`=0, `clock_enable`=1, all pulses 0. Up pressed in RUN → no pulses.
- Mode pressed one cycle → `mode`=1, `clock_enable`=0. Up pressed one cycle → exactly one `hour_inc` pulse, one cycle after the sample edge.
- In SET_MIN, down held 6 cycles → `min_dec` pulses at hold cycles 0, 2, 3, 4, 5 (5 pulses). Release → no further pulses.
- In SET_HOUR, up and down both held 4 cycles → zero pulses. Mode and up rising together → `mode`=2, no `hour_inc`.
- Enter SET_HOUR, no buttons for 30 cycles → `mode`=0 and `clock_enable`=1 after edge 30. One button press at cycle 15 restarts the count, so the return happens at cycle 45.
- Assert reset during a held up in SET_MIN, with `btn_up` kept high through and after reset → `mode`=0, no `min_inc` until up is released and pressed again, and then no pulse because the controller is in RUN.

Source files
------------

// File: rtl/watch_pkg.sv
// Mode encoding shared by the time-set controller and the display blink logic.
package watch_pkg;

    typedef logic [1:0] mode_t;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

endpackage

// File: rtl/btn_repeat.sv
// Press/hold-to-repeat event generator for one up/down button level.
module btn_repeat #(
    parameter int unsigned REPEAT_DELAY = 2,
    parameter int unsigned REPEAT_RATE  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    input  logic clr_i,
    output logic event_c
);

    localparam int unsigned CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [CW-1:0] CNT_FIRST = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] CNT_WRAP  = CW'(REPEAT_DELAY + REPEAT_RATE - 1);

    logic          prev_q;
    logic          armed_q;
    logic          armed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_c;
    logic          repeat_c;

    // Repeats only fire for a hold that began with a real press, so a level
    // held through reset never produces an event.
    assign press_c  = level_i & ~prev_q;
    assign repeat_c = level_i & prev_q & armed_q & (cnt_q == CNT_FIRST);
    assign event_c  = press_c | repeat_c;

    // Hold counter next state: clears on release or conflict, wraps to keep the repeat cadence.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!level_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_WRAP) begin
            cnt_d = CNT_FIRST;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (!level_i) begin
            armed_d = 1'b0;
        end else if (press_c) begin
            armed_d = 1'b1;
        end
    end

    // Previous-sample, arm flag and hold counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= level_i;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set controller: RUN/SET_HOUR/SET_MIN mode FSM, event routing and idle timeout.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 30,
    parameter int unsigned REPEAT_DELAY = 2,
    parameter int unsigned REPEAT_RATE  = 1
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       clock_enable,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic [1:0] mode
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    mode_t         state_q;
    mode_t         state_d;
    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;
    logic          mode_prev_q;
    logic          ce_q;
    logic          ce_d;
    logic          hour_inc_q, hour_dec_q, min_inc_q, min_dec_q;
    logic          hour_inc_d, hour_dec_d, min_inc_d, min_dec_d;

    logic          up_evt_c;
    logic          dn_evt_c;
    logic          mode_press_c;
    logic          any_btn_c;
    logic          in_set_c;
    logic          timeout_c;
    logic          clr_c;

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_up (
        .clk     (Clk_1sec),
        .reset   (reset),
        .level_i (btn_up),
        .clr_i   (clr_c),
        .event_c (up_evt_c)
    );

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_down (
        .clk     (Clk_1sec),
        .reset   (reset),
        .level_i (btn_down),
        .clr_i   (clr_c),
        .event_c (dn_evt_c)
    );

    // Conflicts (both levels high, or a mode press alongside an event) suppress pulses and clear hold counters.
    assign mode_press_c = btn_mode & ~mode_prev_q;
    assign any_btn_c    = btn_mode | btn_up | btn_down;
    assign in_set_c     = (state_q == MODE_SET_HOUR) || (state_q == MODE_SET_MIN);
    assign timeout_c    = in_set_c & ~any_btn_c & (idle_q >= IDLE_LAST);
    assign clr_c        = (btn_up & btn_down) | (mode_press_c & (up_evt_c | dn_evt_c));

    // Next state, idle counter and output pulse decode; timeout takes priority over a mode press.
    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        hour_inc_d = 1'b0;
        hour_dec_d = 1'b0;
        min_inc_d  = 1'b0;
        min_dec_d  = 1'b0;

        case (state_q)
            MODE_RUN: begin
                if (mode_press_c) state_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                if (timeout_c)         state_d = MODE_RUN;
                else if (mode_press_c) state_d = MODE_SET_MIN;
            end
            MODE_SET_MIN: begin
                if (timeout_c || mode_press_c) state_d = MODE_RUN;
            end
            default: state_d = MODE_RUN;
        endcase

        if (any_btn_c || (state_d == MODE_RUN) || (state_d != state_q)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IW'(1);
        end

        if (!clr_c) begin
            hour_inc_d = (state_q == MODE_SET_HOUR) & up_evt_c;
            hour_dec_d = (state_q == MODE_SET_HOUR) & dn_evt_c;
            min_inc_d  = (state_q == MODE_SET_MIN)  & up_evt_c;
            min_dec_d  = (state_q == MODE_SET_MIN)  & dn_evt_c;
        end

        ce_d = (state_d == MODE_RUN);
    end

    // State, idle counter and registered outputs.
    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            state_q     <= MODE_RUN;
            idle_q      <= '0;
            mode_prev_q <= 1'b1;
            ce_q        <= 1'b0;
            hour_inc_q  <= 1'b0;
            hour_dec_q  <= 1'b0;
            min_inc_q   <= 1'b0;
            min_dec_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            mode_prev_q <= btn_mode;
            ce_q        <= ce_d;
            hour_inc_q  <= hour_inc_d;
            hour_dec_q  <= hour_dec_d;
            min_inc_q   <= min_inc_d;
            min_dec_q   <= min_dec_d;
        end
    end

    assign mode         = state_q;
    assign clock_enable = ce_q;
    assign hour_inc     = hour_inc_q;
    assign hour_dec     = hour_dec_q;
    assign min_inc      = min_inc_q;
    assign min_dec      = min_dec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed scenarios plus random stimulus against a cycle model.
module tb_watch_set_ctrl;

    localparam int TO = 30;
    localparam int RD = 2;
    localparam int RR = 1;

    logic       clk = 1'b0;
    logic       rst, bm, bu, bd;
    logic       clock_enable, hour_inc, hour_dec, min_inc, min_dec;
    logic [1:0] mode;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         m_state, m_idle, m_age_u, m_age_d;
    bit         m_prev_m, m_prev_u, m_prev_d, m_arm_u, m_arm_d;
    logic [6:0] m_exp;

    always #5 clk = ~clk;

    watch_set_ctrl dut (
        .Clk_1sec     (clk),
        .reset        (rst),
        .btn_mode     (bm),
        .btn_up       (bu),
        .btn_down     (bd),
        .clock_enable (clock_enable),
        .hour_inc     (hour_inc),
        .hour_dec     (hour_dec),
        .min_inc      (min_inc),
        .min_dec      (min_dec),
        .mode         (mode)
    );

    assign obs = {mode, clock_enable, hour_inc, hour_dec, min_inc, min_dec};

    function automatic bit rep_due(int age);
        return (age >= RD) && (((age - RD) % RR) == 0);
    endfunction

    // One edge of the controller, described by its behavioural rules.
    task automatic model_step();
        bit mp, up_p, dn_p, up_e, dn_e, clr, any;
        bit hi, hd, mi, md;
        int ns;
        if (rst) begin
            m_state = 0; m_idle = 0; m_age_u = 0; m_age_d = 0;
            m_prev_m = 1; m_prev_u = 1; m_prev_d = 1; m_arm_u = 0; m_arm_d = 0;
            m_exp = 7'b0;
        end else begin
            mp   = bm && !m_prev_m;
            up_p = bu && !m_prev_u;
            dn_p = bd && !m_prev_d;
            up_e = up_p || (bu && m_prev_u && m_arm_u && rep_due(m_age_u));
            dn_e = dn_p || (bd && m_prev_d && m_arm_d && rep_due(m_age_d));
            clr  = (bu && bd) || (mp && (up_e || dn_e));
            any  = bm || bu || bd;
            hi = !clr && m_state == 1 && up_e;
            hd = !clr && m_state == 1 && dn_e;
            mi = !clr && m_state == 2 && up_e;
            md = !clr && m_state == 2 && dn_e;
            ns = m_state;
            if (m_state != 0 && !any && m_idle + 1 >= TO) ns = 0;
            else if (mp) ns = (m_state + 1) % 3;
            if (any || ns == 0 || ns != m_state) m_idle = 0;
            else if (m_idle < TO) m_idle = m_idle + 1;
            m_age_u = (!bu || clr) ? 0 : m_age_u + 1;
            m_age_d = (!bd || clr) ? 0 : m_age_d + 1;
            if (!bu) m_arm_u = 0; else if (up_p) m_arm_u = 1;
            if (!bd) m_arm_d = 0; else if (dn_p) m_arm_d = 1;
            m_prev_m = bm; m_prev_u = bu; m_prev_d = bd;
            m_state = ns;
            m_exp = {2'(ns), (ns == 0), hi, hd, mi, md};
        end
    endtask

    // Drive inputs away from the edge, clock once, advance the model, settle.
    task automatic tick(input logic r, input logic m, input logic u, input logic d);
        @(negedge clk);
        rst = r; bm = m; bu = u; bd = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        checks++;
        if (obs !== 7'b0) begin
            $display("FAIL reset_values: got %b expected %b", obs, 7'b0); errors++;
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== 7'b00_1_0000) begin
                $display("FAIL run_idle[%0d]: got %b expected %b", i, obs, 7'b00_1_0000); errors++;
            end
        end
        tick(0, 0, 1, 0);
        checks++;
        if (obs !== 7'b00_1_0000 || obs !== m_exp) begin
            $display("FAIL run_up_discard: got %b expected %b", obs, 7'b00_1_0000); errors++;
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_set_hour();
        tick(0, 1, 0, 0);
        checks++;
        if (mode !== 2'd1 || clock_enable !== 1'b0) begin
            $display("FAIL enter_set_hour: got mode=%0d ce=%b expected mode=1 ce=0", mode, clock_enable); errors++;
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        checks++;
        if (obs !== 7'b01_0_1000 || obs !== m_exp) begin
            $display("FAIL hour_inc_press: got %b expected %b", obs, 7'b01_0_1000); errors++;
        end
        tick(0, 0, 0, 0);
        checks++;
        if (hour_inc !== 1'b0) begin
            $display("FAIL hour_inc_width: got %b expected 0", hour_inc); errors++;
        end
    endtask

    task automatic test_repeat();
        logic [5:0] pat;
        pat = 6'b111101;
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (mode !== 2'd2) begin
            $display("FAIL enter_set_min: got %0d expected 2", mode); errors++;
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 1);
            checks++;
            if (min_dec !== pat[i] || obs !== m_exp) begin
                $display("FAIL min_dec_repeat[%0d]: got %b (obs %b) expected %b (obs %b)",
                         i, min_dec, obs, pat[i], m_exp); errors++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs[3:0] !== 4'b0) begin
                $display("FAIL release_quiet[%0d]: got %b expected 0000", i, obs[3:0]); errors++;
            end
        end
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 1);
            checks++;
            if (obs !== 7'b01_0_0000 || obs !== m_exp) begin
                $display("FAIL both_held[%0d]: got %b expected %b", i, obs, 7'b01_0_0000); errors++;
            end
        end
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        checks++;
        if (obs !== 7'b10_0_0000 || obs !== m_exp) begin
            $display("FAIL mode_wins: got %b expected %b", obs, 7'b10_0_0000); errors++;
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        logic [1:0] exp_mode;
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            tick(0, 0, 0, 0);
            exp_mode = (i < TO) ? 2'd1 : 2'd0;
            checks++;
            if (mode !== exp_mode || clock_enable !== (exp_mode == 2'd0) || obs !== m_exp) begin
                $display("FAIL timeout[%0d]: got mode=%0d ce=%b expected mode=%0d", i, mode, clock_enable, exp_mode);
                errors++;
            end
        end
        tick(0, 1, 0, 0);
        for (int i = 1; i <= TO + 15; i++) begin
            tick(0, 0, 0, (i == 15));
            exp_mode = (i < TO + 15) ? 2'd1 : 2'd0;
            checks++;
            if (mode !== exp_mode || obs !== m_exp) begin
                $display("FAIL timeout_restart[%0d]: got mode=%0d expected mode=%0d", i, mode, exp_mode);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0);
            checks++;
            if (obs !== m_exp) begin
                $display("FAIL hold_before_reset[%0d]: got %b expected %b", i, obs, m_exp); errors++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 1, 0);
            checks++;
            if (obs !== 7'b0) begin
                $display("FAIL reset_mid_hold[%0d]: got %b expected %b", i, obs, 7'b0); errors++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 0);
            checks++;
            if (obs !== 7'b00_1_0000) begin
                $display("FAIL held_after_reset[%0d]: got %b expected %b", i, obs, 7'b00_1_0000); errors++;
            end
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        checks++;
        if (obs !== 7'b00_1_0000 || obs !== m_exp) begin
            $display("FAIL repress_in_run: got %b expected %b", obs, 7'b00_1_0000); errors++;
        end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic r, m, u, d;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            m = ($urandom_range(0, 11) == 0);
            u = ($urandom_range(0, 4) == 0) ? ~bu : bu;
            d = ($urandom_range(0, 5) == 0) ? ~bd : bd;
            tick(r, m, u, d);
            checks++;
            if (obs !== m_exp || $countones(obs[3:0]) > 1) begin
                $display("FAIL random[%0d]: got %b expected %b", i, obs, m_exp); errors++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; bm = 1'b0; bu = 1'b0; bd = 1'b0;
        test_reset();
        test_set_hour();
        test_repeat();
        test_conflict();
        test_timeout();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
